// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter fronting one shared ALU with a single-entry response register
//
// Purpose:
//   N_REQ requesters compete for one shared ALU. A round-robin pointer picks
//   the winner. The winner's operands and opcode are steered to the ALU in the
//   grant cycle, and the ALU's outputs are captured into a one-deep response
//   register. A new grant is issued only when that register is empty or is
//   being drained in the same cycle, so the arbiter sustains one op per cycle.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_req                   per-requester request, held until granted
//   i_a, i_b, i_opcode      packed operands/opcodes, slice k = requester k
//   o_gnt                   one-hot accept pulse (combinational)
//   o_alu_a/b/op            operands driven to the shared ALU (zero when idle)
//   i_alu_result/zero/cf    shared ALU outputs
//   o_valid, i_rsp_ready    response handshake
//   o_id                    requester owning the held response
//   o_result, o_zero, o_cf  registered ALU outputs

`ifndef WORD
`define WORD 8
`endif
`ifndef OP_WIDTH
`define OP_WIDTH 4
`endif

module alu_arbiter #(
    parameter int WIDTH    = `WORD,
    parameter int OP_WIDTH = `OP_WIDTH,
    parameter int N_REQ    = 4,
    localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ*WIDTH-1:0]    i_a,
    input  logic [N_REQ*WIDTH-1:0]    i_b,
    input  logic [N_REQ*OP_WIDTH-1:0] i_opcode,
    output logic [N_REQ-1:0]          o_gnt,
    output logic [WIDTH-1:0]          o_alu_a,
    output logic [WIDTH-1:0]          o_alu_b,
    output logic [OP_WIDTH-1:0]       o_alu_op,
    input  logic [WIDTH-1:0]          i_alu_result,
    input  logic                      i_alu_zero,
    input  logic                      i_alu_cf,
    output logic                      o_valid,
    input  logic                      i_rsp_ready,
    output logic [ID_W-1:0]           o_id,
    output logic [WIDTH-1:0]          o_result,
    output logic                      o_zero,
    output logic                      o_cf
);

    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     win;
    logic [ID_W-1:0]     scan;
    logic                found;
    logic                slot_free;
    logic                grant;

    logic [WIDTH-1:0]    a_arr  [N_REQ];
    logic [WIDTH-1:0]    b_arr  [N_REQ];
    logic [OP_WIDTH-1:0] op_arr [N_REQ];

    // Increment modulo N_REQ so the pointer never leaves 0..N_REQ-1, even
    // when N_REQ is not a power of two.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
        return (v == ID_W'(N_REQ - 1)) ? '0 : v + 1'b1;
    endfunction

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign a_arr[k]  = i_a[k*WIDTH +: WIDTH];
        assign b_arr[k]  = i_b[k*WIDTH +: WIDTH];
        assign op_arr[k] = i_opcode[k*OP_WIDTH +: OP_WIDTH];
    end

    // Scan upward from ptr with wrap; the first asserted request wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        scan  = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && i_req[scan]) begin
                found = 1'b1;
                win   = scan;
            end
            scan = wrap_inc(scan);
        end
    end

    // The response slot can take a new result if it is empty or being drained now.
    assign slot_free = !o_valid || i_rsp_ready;
    assign grant     = slot_free && found && !i_rst;

    assign o_gnt    = grant ? (N_REQ'(1) << win) : '0;
    assign o_alu_a  = grant ? a_arr[win]  : '0;
    assign o_alu_b  = grant ? b_arr[win]  : '0;
    assign o_alu_op = grant ? op_arr[win] : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr      <= '0;
            o_valid  <= 1'b0;
            o_id     <= '0;
            o_result <= '0;
            o_zero   <= 1'b0;
            o_cf     <= 1'b0;
        end else if (grant) begin
            // A grant reloads the slot even if it is being consumed this cycle.
            ptr      <= wrap_inc(win);
            o_valid  <= 1'b1;
            o_id     <= win;
            o_result <= i_alu_result;
            o_zero   <= i_alu_zero;
            o_cf     <= i_alu_cf;
        end else if (o_valid && i_rsp_ready) begin
            // Drained without a replacement; payload is left as-is.
            o_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with behavioural reference model
module tb_alu_arbiter;

    localparam int W  = 8;
    localparam int OW = 4;
    localparam int N  = 4;

    localparam logic [3:0] OP_SUM = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic [N-1:0]    i_req;
    logic [N*W-1:0]  i_a, i_b;
    logic [N*OW-1:0] i_opcode;
    logic [N-1:0]    o_gnt;
    logic [W-1:0]    o_alu_a, o_alu_b;
    logic [OW-1:0]   o_alu_op;
    logic [W-1:0]    alu_result;
    logic            alu_zero, alu_cf;
    logic            o_valid;
    logic            i_rsp_ready;
    logic [1:0]      o_id;
    logic [W-1:0]    o_result;
    logic            o_zero, o_cf;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit       m_valid;
    bit [7:0] m_result;
    bit       m_zero, m_cf;
    int       m_id;
    int       m_ptr;

    always #5 i_clk = ~i_clk;

    // Behavioural ALU: {cf, zero, result}
    function automatic logic [9:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        logic [8:0] wide;
        logic [7:0] r;
        logic       c;
        c = 1'b0;
        case (op)
            OP_SUM: begin wide = {1'b0, a} + {1'b0, b}; r = wide[7:0]; c = wide[8]; end
            OP_SUB: begin r = a - b; c = (a < b); end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            default: r = 8'h00;
        endcase
        return {c, (r == 8'h00), r};
    endfunction

    always_comb {alu_cf, alu_zero, alu_result} = alu_ref(o_alu_a, o_alu_b, o_alu_op);

    alu_arbiter #(.WIDTH(W), .OP_WIDTH(OW), .N_REQ(N)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req        (i_req),
        .i_a          (i_a),
        .i_b          (i_b),
        .i_opcode     (i_opcode),
        .o_gnt        (o_gnt),
        .o_alu_a      (o_alu_a),
        .o_alu_b      (o_alu_b),
        .o_alu_op     (o_alu_op),
        .i_alu_result (alu_result),
        .i_alu_zero   (alu_zero),
        .i_alu_cf     (alu_cf),
        .o_valid      (o_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_id         (o_id),
        .o_result     (o_result),
        .o_zero       (o_zero),
        .o_cf         (o_cf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_valid"},  32'(o_valid),  32'(m_valid));
        chk({tag, "_result"}, 32'(o_result), 32'(m_result));
        chk({tag, "_zero"},   32'(o_zero),   32'(m_zero));
        chk({tag, "_cf"},     32'(o_cf),     32'(m_cf));
        chk({tag, "_id"},     32'(o_id),     32'(m_id));
    endtask

    function automatic logic [31:0] put8(input int k, input logic [7:0] v);
        return 32'(v) << (8 * k);
    endfunction

    function automatic logic [15:0] put4(input int k, input logic [3:0] v);
        return 16'(v) << (4 * k);
    endfunction

    // One clock cycle: drive between posedge and negedge, check at negedge,
    // advance the model at posedge. Returns the model winner and DUT grant.
    task automatic step(input string tag, input logic [3:0] req, input logic [31:0] a,
                        input logic [31:0] b, input logic [15:0] op, input logic ready,
                        output int win, output logic [3:0] gnt_obs);
        bit         free;
        logic [7:0] ea, eb;
        logic [3:0] eop;
        logic [9:0] r;
        i_req = req; i_a = a; i_b = b; i_opcode = op; i_rsp_ready = ready;
        @(negedge i_clk);
        free = !m_valid || ready;
        win  = -1;
        if (free)
            for (int i = 0; i < N; i++)
                if (win < 0 && req[(m_ptr + i) % N]) win = (m_ptr + i) % N;
        ea = 0; eb = 0; eop = 0;
        if (win >= 0) begin
            ea  = a[8*win +: 8];
            eb  = b[8*win +: 8];
            eop = op[4*win +: 4];
        end
        gnt_obs = o_gnt;
        chk({tag, "_gnt"},   32'(o_gnt),   (win >= 0) ? (32'd1 << win) : 32'd0);
        chk({tag, "_alu_a"}, 32'(o_alu_a), 32'(ea));
        chk({tag, "_alu_b"}, 32'(o_alu_b), 32'(eb));
        chk({tag, "_alu_op"},32'(o_alu_op),32'(eop));
        chk_regs(tag);
        @(posedge i_clk);
        if (win >= 0) begin
            r = alu_ref(ea, eb, eop);
            {m_cf, m_zero, m_result} = r;
            m_id    = win;
            m_valid = 1'b1;
            m_ptr   = (win + 1) % N;
        end else if (m_valid && ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic model_reset();
        m_valid = 0; m_result = 0; m_zero = 0; m_cf = 0; m_id = 0; m_ptr = 0;
    endtask

    // Called between posedge and negedge; asserts reset without a clock edge.
    task automatic async_reset(input string tag);
        i_rst = 1'b1;
        i_req = 4'hF;
        i_rsp_ready = 1'b1;
        #1;
        model_reset();
        chk({tag, "_gnt"}, 32'(o_gnt), 32'd0);
        chk_regs(tag);
        #1;
        i_rst = 1'b0;
        i_req = 4'h0;
    endtask

    initial begin
        int         win;
        logic [3:0] g;
        logic [3:0] drop;
        int         order [5] = '{0, 1, 2, 3, 0};

        i_rst = 1'b1; i_req = 0; i_a = 0; i_b = 0; i_opcode = 0; i_rsp_ready = 0;
        model_reset();
        #1;
        chk("reset_gnt", 32'(o_gnt), 32'd0);
        chk_regs("reset");
        @(posedge i_clk); @(posedge i_clk); #1;
        i_rst = 1'b0;

        // Single request, ADD
        step("single", 4'b0001, put8(0, 8'h0F), put8(0, 8'h01), put4(0, OP_SUM), 1'b1, win, g);
        chk("single_gnt_lit", 32'(g), 32'h1);
        chk("single_valid_lit", 32'(o_valid), 32'd1);
        chk("single_result_lit", 32'(o_result), 32'h10);
        chk("single_id_lit", 32'(o_id), 32'd0);
        step("drain0", 4'b0000, 0, 0, 0, 1'b1, win, g);

        // Round-robin with drop/re-raise
        async_reset("rst_rr");
        drop = 4'h0;
        for (int i = 0; i < 5; i++) begin
            step("rr", 4'hF & ~drop, $urandom, $urandom, 16'h4321, 1'b1, win, g);
            chk("rr_order", 32'(g), 32'd1 << order[i]);
            chk("rr_valid_lit", 32'(o_valid), 32'd1);
            drop = (win >= 0) ? (4'd1 << win) : 4'd0;
        end
        step("drain1", 4'b0000, 0, 0, 0, 1'b1, win, g);

        // Backpressure, SUB giving zero
        step("bp_grant", 4'b0010, put8(1, 8'h05), put8(1, 8'h05), put4(1, OP_SUB), 1'b0, win, g);
        for (int i = 0; i < 3; i++) begin
            step("bp_hold", 4'b0010, put8(1, 8'h07), put8(1, 8'h03), put4(1, OP_SUM), 1'b0, win, g);
            chk("bp_nogrant_lit", 32'(g), 32'd0);
            chk("bp_result_lit", 32'(o_result), 32'h00);
            chk("bp_zero_lit", 32'(o_zero), 32'd1);
        end
        step("bp_release", 4'b0010, put8(1, 8'h07), put8(1, 8'h03), put4(1, OP_SUM), 1'b1, win, g);
        chk("bp_release_gnt_lit", 32'(g), 32'h2);
        chk("bp_release_result_lit", 32'(o_result), 32'h0A);

        // Carry / borrow
        step("carry", 4'b0100, put8(2, 8'hFF), put8(2, 8'h01), put4(2, OP_SUM), 1'b1, win, g);
        chk("carry_cf_lit", 32'(o_cf), 32'd1);
        chk("carry_zero_lit", 32'(o_zero), 32'd1);
        step("borrow", 4'b1000, put8(3, 8'h01), put8(3, 8'h02), put4(3, OP_SUB), 1'b1, win, g);
        chk("borrow_result_lit", 32'(o_result), 32'hFF);
        chk("borrow_cf_lit", 32'(o_cf), 32'd1);

        // Async reset while valid, then req=0100 from ptr 0
        async_reset("rst_mid");
        step("post_rst", 4'b0100, put8(2, 8'h11), put8(2, 8'h22), put4(2, OP_XOR), 1'b1, win, g);
        chk("post_rst_gnt_lit", 32'(g), 32'h4);

        // Undefined opcode from requester 3
        step("undef", 4'b1000, put8(3, 8'hAA), put8(3, 8'h55), put4(3, 4'hF), 1'b1, win, g);
        chk("undef_result_lit", 32'(o_result), 32'h00);
        chk("undef_zero_lit", 32'(o_zero), 32'd1);
        chk("undef_id_lit", 32'(o_id), 32'd3);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [15:0] rop;
            for (int k = 0; k < N; k++) rop[4*k +: 4] = 4'($urandom_range(0, 7));
            step("rand", 4'($urandom), $urandom, $urandom, rop,
                 ($urandom_range(0, 3) != 0), win, g);
            if (i == 200) async_reset("rand_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default `WORD, operand/result width.
REQ-002 Parameter OP_WIDTH, default `OP_WIDTH, opcode width.
REQ-003 Parameter N_REQ, default 4, number of requesters (2..8); ID_W = clog2(N_REQ).
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 i_clk  in  1  clock, all state on rising edge.
REQ-006 i_rst  in  1  asynchronous active-high reset.
REQ-007 i_req  in  N_REQ  per-requester request, held until granted.
REQ-008 i_a, i_b  in  N_REQ*WIDTH  packed operands, slice k belongs to requester k.
REQ-009 i_opcode  in  N_REQ*OP_WIDTH  packed opcodes, slice k belongs to requester k.
REQ-010 o_gnt  out  N_REQ  one-hot accept pulse; request consumed in that cycle.
REQ-011 o_alu_a, o_alu_b, o_alu_op  out  WIDTH/WIDTH/OP_WIDTH  drive to the shared alu instance.
REQ-012 i_alu_result, i_alu_zero, i_alu_cf  in  WIDTH/1/1  returned from the shared alu.
REQ-013 o_valid  out  1  response register holds a result.
REQ-014 i_rsp_ready  in  1  consumer accepts response when o_valid && i_rsp_ready.
REQ-015 o_id  out  ID_W  index of the requester owning the response.
REQ-016 o_result, o_zero, o_cf  out  WIDTH/1/1  registered alu outputs.

Function
REQ-017 Slot free (combinational) = !o_valid || i_rsp_ready.
REQ-018 When slot free and |i_req, exactly one o_gnt bit asserts in that cycle; otherwise o_gnt = 0.
REQ-019 Winner = first asserted i_req scanning upward (with wrap) from pointer ptr; ptr resets to 0.
REQ-020 On grant to k, ptr <= (k+1) mod N_REQ at the next edge; without grant ptr holds.
REQ-021 In the grant cycle o_alu_a/b/op equal requester k's slices; with no grant they are all zero.
REQ-022 On grant edge: o_result/o_zero/o_cf <= i_alu_result/zero/cf, o_id <= k, o_valid <= 1; latency request-granted to o_valid is 1 cycle.
REQ-023 On o_valid && i_rsp_ready with no grant: o_valid <= 0; o_result/o_id hold their values.
REQ-024 Simultaneous consume and grant: register reloads with new result, o_valid stays 1; throughput 1 op/cycle.
REQ-025 While o_valid && !i_rsp_ready: no grants, o_result/o_zero/o_cf/o_id stable.
REQ-026 i_req deasserted before grant: request withdrawn, no op, ptr unaffected.
REQ-027 Opcodes are not decoded; undefined opcodes pass through, and the returned result (alu default 0, o_zero=1) is captured unchanged.
REQ-028 N_REQ not a power of two: ptr wraps from N_REQ-1 to 0; ptr never exceeds N_REQ-1.

Reset
REQ-029 i_rst asserted: immediately o_valid=0, o_gnt=0, o_id=0, o_result=0, o_zero=0, o_cf=0, ptr=0, independent of i_clk.
REQ-030 Reset mid-operation discards any held response; no grant is issued while i_rst is high.
REQ-031 First rising edge after i_rst deasserts may grant.

Verification (WIDTH=8, N_REQ=4)
REQ-032 Single request: req=0001, a=0x0F, b=0x01, OP_SUM, ready=1 -> o_gnt=0001 same cycle; next cycle o_valid=1, o_id=0, o_result=0x10, o_cf=0, o_zero=0.
REQ-033 Round-robin: req=1111 held, each granted requester drops req the cycle after its grant and re-raises it the following cycle, ready=1 -> grant order 0,1,2,3,0; one o_valid per cycle.
REQ-034 Backpressure: req=0010, a=0x05, b=0x05, OP_SUB, ready=0 for 3 cycles -> o_valid=1, o_result=0x00, o_zero=1, o_cf=0 stable, no further grants; ready=1 -> pending request granted the same cycle.
REQ-035 Carry/borrow: a=0xFF, b=0x01, OP_SUM -> o_result=0x00, o_cf=1, o_zero=1; a=0x01, b=0x02, OP_SUB -> o_result=0xFF, o_cf=1.
REQ-036 Async reset: assert i_rst mid-cycle while o_valid=1 -> outputs zero before next edge; after release, req=0100 -> granted (ptr=0, scan reaches 2).
REQ-037 Undefined opcode: requester 3 issues an unused opcode, a=0xAA, b=0x55 -> o_result=0x00, o_zero=1, o_cf=0, o_id=3.
